// File: rtl/alu_pkg.sv
// Shared constants and types for the accumulator/sequencer stage around the 3-bit ALU.
package alu_pkg;

  localparam int unsigned W_DEFAULT     = 3;
  localparam int unsigned CNT_W_DEFAULT = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_acc_seq.sv
// Command sequencer + accumulator that chains an external combinational ALU.
// Optional build macro ALU_STICKY_CARRY_EN: carry flag ORs across ops until a load.
module alu_acc_seq
  import alu_pkg::*;
#(
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_b,
  input  logic [1:0]       in_sel,
  input  logic             in_load,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [1:0]       alu_sel,
  input  logic [W-1:0]     alu_y,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_y,
  output logic             out_cout,
  output logic [CNT_W-1:0] op_cnt
);

  state_t           state_q, state_d;
  logic             accept;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     b_q;
  logic [1:0]       sel_q;
  logic             load_q;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (out_ready) state_d = in_valid ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Upstream ready: a finishing response frees the slot in the same cycle
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      RESP:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;
  end

  // Accumulator, flag and counter update at the end of EXEC
  always_comb begin
    acc_d  = acc_q;
    flag_d = flag_q;
    cnt_d  = cnt_q;
    if (state_q == EXEC) begin
      if (load_q) begin
        acc_d  = b_q;
        flag_d = 1'b0;
      end else begin
        acc_d  = alu_y;
`ifdef ALU_STICKY_CARRY_EN
        flag_d = flag_q | alu_cout;
`else
        flag_d = alu_cout;
`endif
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= '0;
      flag_q      <= 1'b0;
      cnt_q       <= '0;
      b_q         <= '0;
      sel_q       <= 2'b00;
      load_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      flag_q      <= flag_d;
      cnt_q       <= cnt_d;
      out_valid_q <= (state_d == RESP);
      if (accept) begin
        b_q    <= in_b;
        sel_q  <= in_sel;
        load_q <= in_load;
      end
    end
  end

  assign alu_a     = acc_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign out_valid = out_valid_q;
  assign out_y     = acc_q;
  assign out_cout  = flag_q;
  assign op_cnt    = cnt_q;

endmodule
